// File: rtl/instruction_loader.sv
// instruction_loader
//   Assembles a program received one byte at a time (big-endian, first byte
//   into bits 31:24) into instruction words and writes each complete word to
//   instruction memory with a one-cycle strobe. A load ends when the halt
//   word is written or when memory is full.
//
// Ports
//   i_clk                 clock, rising edge
//   i_reset               synchronous reset, active low
//   i_start               load request (honoured in IDLE and DONE)
//   i_rx_data/i_rx_valid  incoming program byte, one per valid cycle
//   o_instruction_address byte address of the word being written
//   o_instruction         assembled word
//   o_flag_write_intruc   one-cycle memory write strobe
//   o_busy / o_done       high in RECV / DONE
//   o_full                load ended on capacity, not on the halt word
//   o_word_count          words written in the current or last load
module instruction_loader #(
  parameter int                   BITS_SIZE  = 32,
  parameter int                   SIZE_TOTAL = 256,
  parameter logic [BITS_SIZE-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  output logic [BITS_SIZE-1:0] o_instruction_address,
  output logic [BITS_SIZE-1:0] o_instruction,
  output logic                 o_flag_write_intruc,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_full,
  output logic [7:0]           o_word_count
);

  localparam int WORDS = SIZE_TOTAL / 4;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t               state, state_next;
  logic [1:0]           byte_cnt;
  logic [23:0]          word_buf;   // up to three bytes of a partial word
  logic [7:0]           word_count;
  logic                 start_load, accept, last_byte, is_halt, at_cap;
  logic [BITS_SIZE-1:0] assembled;

  assign start_load = i_start && (state == IDLE || state == DONE);
  assign accept     = (state == RECV) && i_rx_valid;
  assign last_byte  = accept && (byte_cnt == 2'd3);
  assign assembled  = BITS_SIZE'({word_buf, i_rx_data});
  assign is_halt    = (assembled == HALT_WORD);
  assign at_cap     = (word_count == 8'(WORDS - 1));

  assign o_word_count = word_count;

  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (i_start) state_next = RECV;
      RECV:       if (last_byte && (is_halt || at_cap)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_instruction         <= '0;
      o_instruction_address <= '0;
      o_flag_write_intruc   <= 1'b0;
      o_busy                <= 1'b0;
      o_done                <= 1'b0;
      o_full                <= 1'b0;
      word_count            <= '0;
      byte_cnt              <= '0;
      word_buf              <= '0;
    end else begin
      // Status flags follow the next state so they line up with the state.
      o_busy              <= (state_next == RECV);
      o_done              <= (state_next == DONE);
      o_flag_write_intruc <= 1'b0;
      if (start_load) begin
        byte_cnt              <= '0;
        word_buf              <= '0;
        word_count            <= '0;
        o_full                <= 1'b0;
        o_instruction_address <= '0;
      end else if (last_byte) begin
        o_instruction         <= assembled;
        o_instruction_address <= BITS_SIZE'({word_count, 2'b00});
        o_flag_write_intruc   <= 1'b1;
        word_count            <= word_count + 8'd1;
        byte_cnt              <= '0;
        // The halt word wins over capacity when both coincide.
        if (at_cap && !is_halt) o_full <= 1'b1;
      end else if (accept) begin
        word_buf <= {word_buf[15:0], i_rx_data};
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
module tb_instruction_loader;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_rx_valid;
  logic [7:0]  i_rx_data;
  logic [31:0] o_instruction_address, o_instruction;
  logic        o_flag_write_intruc, o_busy, o_done, o_full;
  logic [7:0]  o_word_count;

  instruction_loader dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_instruction_address(o_instruction_address),
    .o_instruction(o_instruction),
    .o_flag_write_intruc(o_flag_write_intruc),
    .o_busy(o_busy), .o_done(o_done), .o_full(o_full),
    .o_word_count(o_word_count)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
    int          c;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Every strobe must match the oldest expected write, including its cycle.
  always @(negedge i_clk) begin
    if (o_flag_write_intruc) begin
      if (sb.size() == 0) chk("spurious_strobe", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", o_instruction_address, e.addr);
        chk("wr_word", o_instruction, e.word);
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] word);
    exp_t e;
    e.addr = addr; e.word = word; e.c = cyc;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    tick();
    i_rx_valid = 1'b0;
  endtask

  // Sends four bytes back-to-back; registers the expected write after the
  // fourth byte's edge when a write is expected.
  task automatic send_word(input logic [31:0] w, input bit wr, input logic [31:0] addr);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    if (wr) expect_wr(addr, w);
  endtask

  task automatic start_load;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic do_reset;
    i_reset = 1'b0;
    tick();
    i_reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  o_instruction_address, 32'd0);
    chk({tag, "_instr"}, o_instruction, 32'd0);
    chk({tag, "_flags"}, {28'd0, o_flag_write_intruc, o_busy, o_done, o_full}, 32'd0);
    chk({tag, "_wc"},    32'(o_word_count), 32'd0);
  endtask

  task automatic drain(input string tag);
    tick(); tick();
    chk({tag, "_missing_wr"}, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    tick(); tick();
    i_reset = 1'b1;
    chk_all_zero("reset");

    // Basic load ending on the halt word.
    start_load();
    chk("basic_busy", {31'd0, o_busy}, 32'd1);
    send_word(32'h20080005, 1'b1, 32'h0);
    send_word(32'hFFFFFFFF, 1'b1, 32'h4);
    tick();
    chk("basic_done", {30'd0, o_done, o_busy}, 32'b10);
    chk("basic_full", {31'd0, o_full}, 32'd0);
    chk("basic_wc", 32'(o_word_count), 32'd2);
    drain("basic");

    // Restart from DONE, then a word with 3 idle cycles between bytes.
    start_load();
    chk("restart_state", {30'd0, o_done, o_busy}, 32'b01);
    chk("restart_wc", 32'(o_word_count), 32'd0);
    begin
      logic [31:0] w;
      w = 32'hDEADBEEF;
      for (int i = 3; i >= 0; i--) begin
        send_byte(w[8*i +: 8]);
        if (i != 0) begin tick(); tick(); tick(); end
      end
      expect_wr(32'h0, w);
    end
    tick();
    chk("gap_wc", 32'(o_word_count), 32'd1);

    // i_start in RECV must not clear the address.
    start_load();
    send_word(32'h12345678, 1'b1, 32'h4);
    tick();
    chk("hold_instr", o_instruction, 32'h12345678);
    chk("hold_addr", o_instruction_address, 32'h4);
    send_word(32'hFFFFFFFF, 1'b1, 32'h8);
    drain("restart");

    // Bytes with no start are ignored.
    do_reset();
    send_word(32'hA1B2C3D4, 1'b0, 32'h0);
    tick();
    chk("nostart_busy", {31'd0, o_busy}, 32'd0);
    chk("nostart_wc", 32'(o_word_count), 32'd0);

    // Reset mid-word discards the partial word.
    start_load();
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    chk_all_zero("midreset");
    start_load();
    send_word(32'hCAFEF00D, 1'b1, 32'h0);
    drain("midreset");

    // Capacity: 64 non-halt words, then a 65th that must be dropped.
    do_reset();
    start_load();
    for (int i = 0; i < 64; i++) send_word(32'h0100_0000 + 32'(i), 1'b1, 32'(4 * i));
    tick();
    chk("cap_done", {30'd0, o_done, o_busy}, 32'b10);
    chk("cap_full", {31'd0, o_full}, 32'd1);
    chk("cap_wc", 32'(o_word_count), 32'd64);
    send_word(32'h0BADBEEF, 1'b0, 32'h0);
    tick();
    chk("cap_after_wc", 32'(o_word_count), 32'd64);
    chk("cap_hold_addr", o_instruction_address, 32'hFC);
    drain("cap");

    // Capacity word that is also the halt word: not full.
    start_load();
    for (int i = 0; i < 63; i++) send_word(32'h0200_0000 + 32'(i), 1'b1, 32'(4 * i));
    send_word(32'hFFFFFFFF, 1'b1, 32'hFC);
    tick();
    chk("caphalt_done", {31'd0, o_done}, 32'd1);
    chk("caphalt_full", {31'd0, o_full}, 32'd0);
    chk("caphalt_wc", 32'(o_word_count), 32'd64);
    drain("caphalt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
